// File: rtl/seq_divider_8bit.sv
// seq_divider_8bit: 16/8 unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Optional macro DIV_ERR_CHECK_EN enables divide-by-zero and quotient-overflow early exit.
module seq_divider_8bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [7:0]  quotient,
    output logic [7:0]  remainder,
    output logic        dbz,
    output logic        ovf
);
    typedef enum logic [1:0] {IDLE, CHECK, CALC, DONE} state_t;
    state_t     r_state;
    logic [7:0] r_r;
    logic [7:0] r_q;
    logic [7:0] r_d;
    logic [2:0] r_cnt;
    logic       w_ge;
    logic [7:0] w_t;
    logic [7:0] w_r_next;
    logic [7:0] w_q_next;
    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        w_ge     = {r_r, r_q[7]} >= {1'b0, r_d};
        w_t      = {r_r[6:0], r_q[7]} - r_d;
        w_r_next = w_ge ? w_t : {r_r[6:0], r_q[7]};
        w_q_next = {r_q[6:0], w_ge};
    end
    // Control FSM and datapath with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_r       <= 8'h00;
            r_q       <= 8'h00;
            r_d       <= 8'h00;
            r_cnt     <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= 8'h00;
            remainder <= 8'h00;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_state <= CHECK;
                        r_r     <= dividend[15:8];
                        r_q     <= dividend[7:0];
                        r_d     <= divisor;
                        dbz     <= 1'b0;
                        ovf     <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CHECK: begin
`ifdef DIV_ERR_CHECK_EN
                    if (r_d == 8'h00) begin
                        r_state   <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        dbz       <= 1'b1;
                        quotient  <= 8'hFF;
                        remainder <= r_q;
                    end else if (r_r >= r_d) begin
                        r_state   <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        ovf       <= 1'b1;
                        quotient  <= 8'hFF;
                        remainder <= 8'hFF;
                    end else begin
                        r_state <= CALC;
                        r_cnt   <= 3'd0;
                    end
`else
                    r_state <= CALC;
                    r_cnt   <= 3'd0;
`endif
                end
                CALC: begin
                    r_r   <= w_r_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state   <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= w_q_next;
                        remainder <= w_r_next;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
